// File: rtl/instruction_fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, runs the instruction-memory read handshake,
// and applies stalls and redirects. A memory request that has been accepted always completes.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend, pend_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic [31:0] id_pc_nxt, id_pc4_nxt, id_instr_nxt;
  logic        id_valid_nxt;

  // During DRAIN the PC is left untouched, so it still carries the in-flight address.
  assign imem_addr = pc;
  assign imem_read = rst_n && (state != HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_nxt       = pend;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    id_pc_nxt      = if_id_pc;
    id_pc4_nxt     = if_id_pc4;
    id_instr_nxt   = if_id_instr;
    id_valid_nxt   = if_id_valid;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          if (!imem_busywait) begin
            pc_nxt = branch_target;
          end else begin
            pend_nxt  = branch_target;
            state_nxt = DRAIN;
          end
        end else if (stall) begin
          if (!imem_busywait) begin
            hold_pc_nxt    = pc;
            hold_instr_nxt = imem_readdata;
            pc_nxt         = pc + 32'd4;
            state_nxt      = HOLD;
          end
        end else if (!imem_busywait) begin
          id_pc_nxt    = pc;
          id_pc4_nxt   = pc + 32'd4;
          id_instr_nxt = imem_readdata;
          id_valid_nxt = 1'b1;
          pc_nxt       = pc + 32'd4;
        end else begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
        end
      end
      DRAIN: begin
        id_instr_nxt = NOP_INSTR;
        id_valid_nxt = 1'b0;
        if (!imem_busywait) begin
          pc_nxt    = branch_taken ? branch_target : pend;
          state_nxt = FETCH;
        end else if (branch_taken) begin
          pend_nxt = branch_target;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          pc_nxt       = branch_target;
          state_nxt    = FETCH;
        end else if (!stall) begin
          id_pc_nxt    = hold_pc;
          id_pc4_nxt   = hold_pc + 32'd4;
          id_instr_nxt = hold_instr;
          id_valid_nxt = 1'b1;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend        <= 32'd0;
      hold_pc     <= 32'd0;
      hold_instr  <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      pend        <= pend_nxt;
      hold_pc     <= hold_pc_nxt;
      hold_instr  <= hold_instr_nxt;
      if_id_pc    <= id_pc_nxt;
      if_id_pc4   <= id_pc4_nxt;
      if_id_instr <= id_instr_nxt;
      if_id_valid <= id_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random stall/branch/busywait traffic,
// checked against a program-order model (next expected PC, word = hash of address).
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic        prev_quiet;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_readdata = memf(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // One clock with the given inputs; entered and left at a falling edge.
  task automatic cycle(input logic s, input logic b, input logic [31:0] t, input logic bw);
    logic [31:0] p_pc, p_pc4, p_instr, p_addr;
    logic        p_valid, p_read, quiet;
    stall = s; branch_taken = b; branch_target = t; imem_busywait = bw;
    p_pc = if_id_pc; p_pc4 = if_id_pc4; p_instr = if_id_instr; p_valid = if_id_valid;
    p_addr = imem_addr; p_read = imem_read;
    quiet = !s && !b && !bw;
    @(posedge clk);
    @(negedge clk);
    if (!if_id_valid) chk("bubble_nop", if_id_instr, NOP);
    if (b) begin
      chk("branch_flush", {31'd0, if_id_valid}, 32'd0);
      exp_pc = t;
    end else if (s) begin
      chk("stall_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
      if (p_valid) begin
        chk("stall_pc", if_id_pc, p_pc);
        chk("stall_pc4", if_id_pc4, p_pc4);
        chk("stall_instr", if_id_instr, p_instr);
      end
    end else if (if_id_valid) begin
      chk("order_pc", if_id_pc, exp_pc);
      chk("instr", if_id_instr, memf(if_id_pc));
      chk("pc4", if_id_pc4, if_id_pc + 32'd4);
      exp_pc = if_id_pc + 32'd4;
    end
    if (quiet && prev_quiet) chk("throughput", {31'd0, if_id_valid}, 32'd1);
    if (p_read && bw) begin
      chk("inflight_read", {31'd0, imem_read}, 32'd1);
      chk("inflight_addr", imem_addr, p_addr);
    end
    prev_quiet = quiet;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_read"}, {31'd0, imem_read}, 32'd0);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_pc"}, if_id_pc, 32'd0);
    chk({tag, "_pc4"}, if_id_pc4, 32'd0);
  endtask

  initial begin
    logic [31:0] t;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; imem_busywait = 1'b0;
    exp_pc = 32'd0; prev_quiet = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    chk("first_addr", imem_addr, 32'd0);

    repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t1_pc", if_id_pc, 32'hC);
    chk("t1_addr", imem_addr, 32'h10);

    repeat (3) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("t2_bubble", {31'd0, if_id_valid}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t2_pc", if_id_pc, 32'h10);

    repeat (2) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      chk("t3_read", {31'd0, imem_read}, 32'd0);
      chk("t3_keep", if_id_pc, 32'h10);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t3_pc", if_id_pc, 32'h14);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t3_next", if_id_pc, 32'h18);

    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    chk("t4_addr", imem_addr, 32'h1C);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_discard", {31'd0, if_id_valid}, 32'd0);
    chk("t4_req", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t4_pc", if_id_pc, 32'h100);

    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h200, 1'b0);
    chk("t5_addr", imem_addr, 32'h200);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t5_pc", if_id_pc, 32'h200);

    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("wrap_pc", if_id_pc, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h4);

    cycle(1'b0, 1'b1, 32'h300, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_checks("t6");
    @(negedge clk);
    rst_n = 1'b1; exp_pc = 32'd0; prev_quiet = 1'b0;
    imem_busywait = 1'b0;
    chk("t6_restart_addr", imem_addr, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t6_pc", if_id_pc, 32'd0);
    chk("t6_valid", {31'd0, if_id_valid}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 9) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
